// File: rtl/vecmem_pkg.sv
// Shared types and constants for the vector result memory and its readout engine.
// A memory word is LANES lanes of LANE_W bits each.
package vecmem_pkg;

  localparam int LANES      = 16;
  localparam int LANE_W     = 16;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rd_state_t;

  // Number of memory vectors that hold a w x h image.
  function automatic int num_vec(input int w, input int h);
    return (w * h) / LANES;
  endfunction

endpackage

// File: rtl/vec_lane_serializer.sv
// Two-deep vector buffer (cur/nxt) that emits the low pixel bits of each lane, lane 0 first.
// o_consumed pulses on the handshake of the last lane of a vector.
module vec_lane_serializer
  import vecmem_pkg::*;
#(
  parameter int PIX_SIZE = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_load,
  input  vec_t                i_load_data,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [PIX_SIZE-1:0] o_pix,
  output logic                o_consumed
);

  logic [LANES-1:0][PIX_SIZE-1:0] w_in_pix;
  logic [LANES-1:0]               w_hi_par;
  logic                           w_unused_hi;
  logic [LANES-1:0][PIX_SIZE-1:0] r_cur;
  logic [LANES-1:0][PIX_SIZE-1:0] r_nxt;
  logic                           r_cur_valid;
  logic                           r_nxt_valid;
  logic [LANE_IDX_W-1:0]          r_lane;
  logic                           w_hs;
  logic                           w_last_lane;
  logic                           w_consume;

  // Only the pixel bits of each lane are buffered; upper lane bits are dropped here.
  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_in_pix[gi] = i_load_data[gi][PIX_SIZE-1:0];
    assign w_hi_par[gi] = ^i_load_data[gi][LANE_W-1:PIX_SIZE];
  end
  assign w_unused_hi = ^w_hi_par;

  assign w_hs        = r_cur_valid && i_ready;
  assign w_last_lane = (r_lane == LANE_IDX_W'(LANES - 1));
  assign w_consume   = w_hs && w_last_lane;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cur       <= '0;
      r_nxt       <= '0;
      r_cur_valid <= 1'b0;
      r_nxt_valid <= 1'b0;
      r_lane      <= '0;
    end else begin
      if (w_hs) begin
        r_lane <= r_lane + 1'b1;
      end
      if (w_consume) begin
        // A refill landing in the same cycle as the last lane goes straight to cur.
        if (r_nxt_valid) begin
          r_cur       <= r_nxt;
          r_nxt_valid <= 1'b0;
        end else if (i_load) begin
          r_cur <= w_in_pix;
        end else begin
          r_cur_valid <= 1'b0;
        end
      end else if (i_load) begin
        if (!r_cur_valid) begin
          r_cur       <= w_in_pix;
          r_cur_valid <= 1'b1;
        end else begin
          r_nxt       <= w_in_pix;
          r_nxt_valid <= 1'b1;
        end
      end
    end
  end

  assign o_valid    = r_cur_valid;
  assign o_pix      = r_cur[r_lane];
  assign o_consumed = w_consume;

endmodule

// File: rtl/wr_image_reader.sv
// Reads a processed image out of the vector result memory and streams it pixel by pixel.
// Owns the memory read port (mem_req/mem_addr) while a readout is running.
module wr_image_reader
  import vecmem_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 192,
  parameter int IMAGE_HEIGHT = 192,
  parameter int PIX_SIZE     = 8,
  parameter int BASE_ADDR    = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  output logic [15:0]         mem_addr,
  input  vec_t                mem_rd_data,
  output logic [PIX_SIZE-1:0] pix_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_eol,
  output logic                pix_last
);

  localparam int NUM_VEC = num_vec(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int NUM_PIX = IMAGE_WIDTH * IMAGE_HEIGHT;

  if (IMAGE_WIDTH % LANES != 0) begin : g_bad_width
    $error("wr_image_reader: IMAGE_WIDTH must be a multiple of LANES");
  end

  rd_state_t   r_state;
  rd_state_t   w_state_next;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_pix_cnt;
  logic [31:0] r_col;
  logic [1:0]  r_held;
  logic        r_mem_req;
  logic        r_rd_valid;
  logic [15:0] r_mem_addr;
  logic        w_issue;
  logic        w_hs;
  logic        w_final_hs;
  logic        w_pix_valid;
  logic        w_consumed;
  logic        w_busy;
  logic        w_done;

  // r_held counts buffered vectors; the returning read (r_rd_valid) is counted as
  // already buffered so that cur and nxt can never both be full when it lands.
  assign w_issue = (r_state == RUN) && (r_fetch_cnt < 32'(NUM_VEC)) && !r_mem_req &&
                   ((r_held + {1'b0, r_rd_valid}) < 2'd2);

  assign w_hs       = w_pix_valid && pix_ready;
  assign w_final_hs = w_hs && (r_pix_cnt == 32'(NUM_PIX - 1));

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = RUN;
      RUN: begin
        w_busy = 1'b1;
        if (w_final_hs) w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_fetch_cnt <= '0;
      r_pix_cnt   <= '0;
      r_col       <= '0;
      r_held      <= '0;
      r_mem_req   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_mem_addr  <= 16'(BASE_ADDR);
    end else begin
      r_state    <= w_state_next;
      r_mem_req  <= w_issue;
      r_rd_valid <= r_mem_req;
      if (r_state == IDLE && start) begin
        r_fetch_cnt <= '0;
        r_pix_cnt   <= '0;
        r_col       <= '0;
        r_held      <= '0;
      end
      if (w_issue) begin
        r_mem_addr  <= 16'(BASE_ADDR) + r_fetch_cnt[15:0];
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_hs) begin
        r_pix_cnt <= r_pix_cnt + 32'd1;
        r_col     <= (r_col == 32'(IMAGE_WIDTH - 1)) ? 32'd0 : r_col + 32'd1;
      end
      case ({r_rd_valid, w_consumed})
        2'b10:   r_held <= r_held + 2'd1;
        2'b01:   r_held <= r_held - 2'd1;
        default: r_held <= r_held;
      endcase
    end
  end

  vec_lane_serializer #(
    .PIX_SIZE(PIX_SIZE)
  ) u_ser (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (r_rd_valid),
    .i_load_data(mem_rd_data),
    .i_ready    (pix_ready),
    .o_valid    (w_pix_valid),
    .o_pix      (pix_data),
    .o_consumed (w_consumed)
  );

  assign busy      = w_busy;
  assign done      = w_done;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign pix_valid = w_pix_valid;
  assign pix_eol   = w_pix_valid && (r_col == 32'(IMAGE_WIDTH - 1));
  assign pix_last  = w_pix_valid && (r_pix_cnt == 32'(NUM_PIX - 1));

endmodule
